nibble_serial_adder: RTL and testbench

Sequencing stage that wraps the existing 4-bit full adder to add two wide operands one nibble per clock. It latches a pair of operands and a carry-in, drives the adder's A/B/carry-in nibble by nibble starting with the LSB, and captures the adder's sum and carry-out each cycle. When the last nibble is done it presents the full-width sum and final carry with a one-cycle done pulse. The 4-bit adder stays purely combinational, and this block supplies its inputs and consumes its outputs.

---
 rtl/nibble_serial_adder_if.sv | 31 +++
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus and the nibble link to the external combinational 4-bit adder.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport slave (
        input  start, op_a, op_b, cin_in, add_s, add_cout,
        output busy, done, sum, cout, add_a, add_b, add_cin
    );

    modport master (
        output start, op_a, op_b, cin_in, add_s, add_cout,
        input  busy, done, sum, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Feeds an external 4-bit adder one nibble per clock, LSB first, and assembles the
// full-width sum; the inter-nibble carry lives only in carry_q.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [NIBBLES-1:0][3:0] a_q, a_d;
    logic [NIBBLES-1:0][3:0] b_q, b_d;
    logic [NIBBLES-1:0][3:0] sum_q, sum_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    last_nib;

    assign last_nib = (idx_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_nib)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder inputs come only from registers, so start/op_* never reach the adder path.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.cin_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                bus.add_a    = a_q[idx_q];
                bus.add_b    = b_q[idx_q];
                bus.add_cin  = carry_q;
                sum_d[idx_q] = bus.add_s;
                carry_d      = bus.add_cout;
                if (last_nib) begin
                    cout_d = bus.add_cout;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed vectors for nibble_serial_adder; expected results go to a scoreboard queue and
// an independent monitor checks each done pulse for value and latency.
module tb_nibble_serial_adder;
    localparam int NIB = 4;

    logic clk;
    logic rst_n;

    nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the existing combinational 4-bit full adder.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

    typedef struct {
        logic [15:0] s;
        logic        c;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_done = 0;
    int   last_done = -1;
    int   prev_done = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            prev_done = last_done;
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", bus.sum, e.s);
                chk("cout", bus.cout, e.c);
                chk("latency", cyc - e.acc, NIB);
            end
        end
    end

    // Called just after a negedge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] es, input logic ec);
        exp_t e;
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.cin_in = ci;
        @(posedge clk);
        #1;
        e.s = es; e.c = ec; e.acc = cyc;
        sb.push_back(e);
        n_push++;
        bus.start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sum"}, bus.sum, 0);
        chk({tag, "_cout"}, bus.cout, 0);
    endtask

    initial begin
        int busy_cnt;
        int done_before;
        exp_t e;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin_in = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("rst");
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_cin", bus.add_cin, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero operands; busy must be high for exactly NIB sampled cycles.
        @(negedge clk);
        issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        chk("busy_cycles", busy_cnt, NIB);

        // Full carry ripple: nibble 0 sees cin 0, nibbles 1..3 see the propagated carry.
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            chk($sformatf("ripple_cin_n%0d", k), bus.add_cin, (k > 0) ? 1 : 0);
        end
        repeat (2) @(negedge clk);

        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        repeat (6) @(negedge clk);
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        repeat (6) @(negedge clk);

        // start re-pulsed with different operands while running must be ignored.
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.cin_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);

        // Abort after two nibbles: outputs clear with no clock edge, no done follows.
        issue(16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0);
        repeat (3) @(negedge clk);
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        e = sb.pop_back();
        n_push--;
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", n_done, done_before);
        issue(16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0);
        repeat (6) @(negedge clk);

        // start held high: the second accept lands on the IDLE cycle that shows done.
        bus.start = 1'b1; bus.op_a = 16'h0F0F; bus.op_b = 16'h00F1; bus.cin_in = 1'b0;
        @(posedge clk);
        #1;
        e.s = 16'h1000; e.c = 1'b0; e.acc = cyc;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
        bus.op_a = 16'h8000; bus.op_b = 16'h8000;
        repeat (NIB + 1) @(posedge clk);
        #1;
        e.s = 16'h0000; e.c = 1'b1; e.acc = cyc;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("b2b_done_gap", last_done - prev_done, NIB + 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("done_count", n_done, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
